// File: rtl/fft_twiddle_sequencer_if.sv
// Twiddle stream bundle between the sequencer (master) and the butterfly datapath (slave).
interface fft_twiddle_sequencer_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic [DATA_W-1:0] tw_re;
    logic [DATA_W-1:0] tw_im;
    logic [IDX_W-1:0]  tw_idx;
    logic [ADDR_W-1:0] tw_stage;
    logic              tw_valid;
    logic              tw_ready;
    logic              tw_last;

    modport master (
        output tw_re, tw_im, tw_idx, tw_stage, tw_valid, tw_last,
        input  tw_ready
    );

    modport slave (
        input  tw_re, tw_im, tw_idx, tw_stage, tw_valid, tw_last,
        output tw_ready
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Walks the stage-indexed twiddle ROM and streams 16 twiddles per stage over valid/ready.
// Define TWIDDLE_PREFETCH_EN to overlap the next stage's ROM read with streaming (no stage gap).
module fft_twiddle_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int ADDR_W     = 3,
    parameter int PAIRS      = 16,
    parameter int DATA_W     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [PAIRS*2*DATA_W-1:0] rom_data,
    fft_twiddle_sequencer_if.master   tw,
    output logic                      busy,
    output logic                      done
);
    localparam int PAIR_W = 2 * DATA_W;
    localparam int WORD_W = PAIRS * PAIR_W;
    localparam int IDX_W  = 4;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PAIRS - 1);
    localparam logic [ADDR_W-1:0] LAST_STAGE = ADDR_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] word_buf;
    logic [IDX_W-1:0]  next_idx;
    logic [ADDR_W-1:0] next_stage;

`ifdef TWIDDLE_PREFETCH_EN
    logic [WORD_W-1:0] pf_buf;
    logic [1:0]        pf_cnt;
`endif

    assign next_idx   = tw.tw_idx + IDX_W'(1);
    assign next_stage = tw.tw_stage + ADDR_W'(1);

    // Pair 0 lives in the MSBs of the ROM word; real in the upper byte of each pair.
    function automatic logic [PAIR_W-1:0] pair_of(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  k);
        return word[WORD_W - 1 - PAIR_W * int'(k) -: PAIR_W];
    endfunction

    // tw_stage/tw_idx double as the walk counters; rom_addr is set on entry to FETCH
    // so the registered ROM has the word ready while in LOAD.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            word_buf    <= '0;
            rom_addr    <= '0;
            tw.tw_re    <= '0;
            tw.tw_im    <= '0;
            tw.tw_idx   <= '0;
            tw.tw_stage <= '0;
            tw.tw_valid <= 1'b0;
            tw.tw_last  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef TWIDDLE_PREFETCH_EN
            pf_buf      <= '0;
            pf_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef TWIDDLE_PREFETCH_EN
            // Address goes out in the first stream cycle; data is captured at the end of the second.
            if (pf_cnt != 2'd0) pf_cnt <= pf_cnt - 2'd1;
            if (pf_cnt == 2'd1) pf_buf <= rom_data;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FETCH;
                        busy        <= 1'b1;
                        tw.tw_stage <= '0;
                        rom_addr    <= '0;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    word_buf                 <= rom_data;
                    tw.tw_idx                <= '0;
                    {tw.tw_re, tw.tw_im}     <= pair_of(rom_data, '0);
                    tw.tw_valid              <= 1'b1;
                    tw.tw_last               <= 1'b0;
                    state                    <= STREAM;
`ifdef TWIDDLE_PREFETCH_EN
                    if (tw.tw_stage != LAST_STAGE) begin
                        rom_addr <= next_stage;
                        pf_cnt   <= 2'd2;
                    end
`endif
                end
                STREAM: begin
                    if (tw.tw_ready) begin
                        if (tw.tw_idx != LAST_IDX) begin
                            tw.tw_idx            <= next_idx;
                            {tw.tw_re, tw.tw_im} <= pair_of(word_buf, next_idx);
                            tw.tw_last           <= (next_idx == LAST_IDX) &&
                                                    (tw.tw_stage == LAST_STAGE);
                        end else if (tw.tw_stage != LAST_STAGE) begin
                            tw.tw_stage <= next_stage;
                            tw.tw_last  <= 1'b0;
`ifdef TWIDDLE_PREFETCH_EN
                            word_buf             <= pf_buf;
                            tw.tw_idx            <= '0;
                            {tw.tw_re, tw.tw_im} <= pair_of(pf_buf, '0);
                            if (next_stage != LAST_STAGE) begin
                                rom_addr <= next_stage + ADDR_W'(1);
                                pf_cnt   <= 2'd2;
                            end
`else
                            tw.tw_valid <= 1'b0;
                            rom_addr    <= next_stage;
                            state       <= FETCH;
`endif
                        end else begin
                            tw.tw_valid <= 1'b0;
                            tw.tw_last  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: bench-owned ROM, transfer log and vector table.
// Honours TWIDDLE_PREFETCH_EN for the expected inter-stage gap count.
module tb_fft_twiddle_sequencer;
    localparam int NUM_STAGES = 5;
    localparam int ADDR_W     = 3;
    localparam int PAIRS      = 16;
    localparam int DATA_W     = 8;
    localparam int WORD_W     = PAIRS * 2 * DATA_W;
    localparam int TOTAL      = NUM_STAGES * PAIRS;
`ifdef TWIDDLE_PREFETCH_EN
    localparam int EXP_GAPS = 0;
`else
    localparam int EXP_GAPS = 2 * (NUM_STAGES - 1);
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data = '0;
    logic              busy;
    logic              done;

    fft_twiddle_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) tw_bus ();

    fft_twiddle_sequencer #(
        .NUM_STAGES(NUM_STAGES), .ADDR_W(ADDR_W), .PAIRS(PAIRS), .DATA_W(DATA_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tw       (tw_bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    logic [WORD_W-1:0] rom [0:7];

    always @(posedge clock) rom_data <= rom[rom_addr];

    typedef struct {
        int         n;
        logic [2:0] stage;
        logic [3:0] idx;
        logic [7:0] re;
        logic [7:0] im;
    } vec_t;

    vec_t vecs [7];

    int checks = 0;
    int passes = 0;

    int n_xfer, n_done, n_last, last_pos, order_err, stall_err, busy_err;
    int latency, gaps;
    bit timed_out, aborted;

    logic [7:0] log_re    [TOTAL];
    logic [7:0] log_im    [TOTAL];
    logic [3:0] log_idx   [TOTAL];
    logic [2:0] log_stage [TOTAL];

    logic [15:0] lfsr = 16'hACE1;

    // Twiddle contents: fixed values from the known-answer list, arbitrary distinct filler elsewhere.
    function automatic logic [15:0] tw_value(input int s, input int k);
        if (s == 1 && k == 0)  return 16'h00C0;
        if (s == 1 && k == 1)  return 16'h4000;
        if (s == 2 && k == 0)  return 16'hADAD;
        if (s == 4 && k == 0)  return 16'hBE8D;
        if (s == 4 && k == 15) return 16'h4000;
        if (s == 0)            return 16'h4000;
        return {8'(s * 37 + k * 11 + 3), 8'(k * 29 + s * 5 + 113)};
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rom_addr"}, int'(rom_addr), 0);
        check_output({tag, "_tw_re"},    int'(tw_bus.tw_re), 0);
        check_output({tag, "_tw_im"},    int'(tw_bus.tw_im), 0);
        check_output({tag, "_tw_idx"},   int'(tw_bus.tw_idx), 0);
        check_output({tag, "_tw_stage"}, int'(tw_bus.tw_stage), 0);
        check_output({tag, "_tw_valid"}, int'(tw_bus.tw_valid), 0);
        check_output({tag, "_tw_last"},  int'(tw_bus.tw_last), 0);
        check_output({tag, "_busy"},     int'(busy), 0);
        check_output({tag, "_done"},     int'(done), 0);
    endtask

    // Pulses start, then watches every cycle at the negedge: drives tw_ready, logs transfers,
    // and tracks stall stability, busy/done, gaps and tw_last. Optionally pokes start mid-run
    // or stops at a given stage/idx so the caller can apply reset.
    task automatic apply_stimulus(input int ready_mode, input bit poke_start,
                                  input int abort_stage, input int abort_idx);
        int          cyc;
        int          tail;
        bit          poked;
        bit          done_seen;
        bit          prev_stall;
        logic [7:0]  p_re, p_im;
        logic [3:0]  p_idx;
        logic [2:0]  p_stage;
        logic        p_last;
        logic [15:0] exp_tw;

        n_xfer = 0; n_done = 0; n_last = 0; last_pos = -1; order_err = 0;
        stall_err = 0; busy_err = 0; latency = -1; gaps = 0;
        timed_out = 1'b0; aborted = 1'b0;
        poked = 1'b0; done_seen = 1'b0; prev_stall = 1'b0; tail = 0;
        p_re = '0; p_im = '0; p_idx = '0; p_stage = '0; p_last = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            log_re[i] = '0; log_im[i] = '0; log_idx[i] = '0; log_stage[i] = '0;
        end

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (1) begin
            if (ready_mode == 0) begin
                tw_bus.tw_ready = 1'b1;
            end else begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                tw_bus.tw_ready = lfsr[0] | lfsr[5];
            end

            start = 1'b0;
            if (poke_start && !poked && tw_bus.tw_valid &&
                tw_bus.tw_stage == 3'd2 && tw_bus.tw_idx == 4'd5) begin
                start = 1'b1;
                poked = 1'b1;
            end

            if (abort_stage >= 0 && tw_bus.tw_valid &&
                int'(tw_bus.tw_stage) == abort_stage && int'(tw_bus.tw_idx) == abort_idx) begin
                aborted = 1'b1;
                break;
            end

            if (tw_bus.tw_valid && latency < 0) latency = cyc;

            if (prev_stall && (!tw_bus.tw_valid || tw_bus.tw_re != p_re || tw_bus.tw_im != p_im ||
                               tw_bus.tw_idx != p_idx || tw_bus.tw_stage != p_stage ||
                               tw_bus.tw_last != p_last))
                stall_err++;

            if (done) begin
                n_done++;
                if (busy) busy_err++;
                done_seen = 1'b1;
            end else if (done_seen == busy) begin
                busy_err++;
            end

            if (n_xfer > 0 && n_xfer < TOTAL && !tw_bus.tw_valid) gaps++;
            if (tw_bus.tw_last && !tw_bus.tw_valid) order_err++;

            if (tw_bus.tw_valid && tw_bus.tw_ready) begin
                if (n_xfer < TOTAL) begin
                    exp_tw = tw_value(n_xfer / PAIRS, n_xfer % PAIRS);
                    if (tw_bus.tw_stage != 3'(n_xfer / PAIRS) || tw_bus.tw_idx != 4'(n_xfer % PAIRS) ||
                        tw_bus.tw_re != exp_tw[15:8] || tw_bus.tw_im != exp_tw[7:0])
                        order_err++;
                    log_re[n_xfer]    = tw_bus.tw_re;
                    log_im[n_xfer]    = tw_bus.tw_im;
                    log_idx[n_xfer]   = tw_bus.tw_idx;
                    log_stage[n_xfer] = tw_bus.tw_stage;
                end else begin
                    order_err++;
                end
                if (tw_bus.tw_last) begin
                    n_last++;
                    last_pos = n_xfer;
                end
                n_xfer++;
            end

            prev_stall = tw_bus.tw_valid && !tw_bus.tw_ready;
            p_re = tw_bus.tw_re; p_im = tw_bus.tw_im; p_idx = tw_bus.tw_idx;
            p_stage = tw_bus.tw_stage; p_last = tw_bus.tw_last;

            if (done_seen) tail++;
            if (tail >= 4) break;
            if (cyc >= 3000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_vector_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            check_output($sformatf("%s_vec%0d_n%0d", tag, i, vecs[i].n),
                         int'({log_stage[vecs[i].n], log_idx[vecs[i].n],
                               log_re[vecs[i].n], log_im[vecs[i].n]}),
                         int'({vecs[i].stage, vecs[i].idx, vecs[i].re, vecs[i].im}));
        end
    endtask

    initial begin
        int spurious_done;

        vecs[0] = '{n: 0,  stage: 3'd0, idx: 4'd0,  re: 8'h40, im: 8'h00};
        vecs[1] = '{n: 15, stage: 3'd0, idx: 4'd15, re: 8'h40, im: 8'h00};
        vecs[2] = '{n: 16, stage: 3'd1, idx: 4'd0,  re: 8'h00, im: 8'hC0};
        vecs[3] = '{n: 17, stage: 3'd1, idx: 4'd1,  re: 8'h40, im: 8'h00};
        vecs[4] = '{n: 32, stage: 3'd2, idx: 4'd0,  re: 8'hAD, im: 8'hAD};
        vecs[5] = '{n: 64, stage: 3'd4, idx: 4'd0,  re: 8'hBE, im: 8'h8D};
        vecs[6] = '{n: 79, stage: 3'd4, idx: 4'd15, re: 8'h40, im: 8'h00};

        for (int s = 0; s < 8; s++) begin
            rom[s] = '0;
            for (int k = 0; k < PAIRS; k++)
                rom[s][WORD_W - 1 - 16 * k -: 16] = tw_value(s, k);
        end

        reset = 1'b1;
        start = 1'b0;
        tw_bus.tw_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] run A: tw_ready held high");
        apply_stimulus(0, 1'b0, -1, 0);
        check_output("A_timeout",   int'(timed_out), 0);
        check_output("A_latency",   latency, 3);
        check_output("A_transfers", n_xfer, TOTAL);
        check_output("A_order",     order_err, 0);
        check_output("A_done",      n_done, 1);
        check_output("A_last_cnt",  n_last, 1);
        check_output("A_last_pos",  last_pos, TOTAL - 1);
        check_output("A_busy",      busy_err, 0);
        check_output("A_gaps",      gaps, EXP_GAPS);
        check_vector_table("A");

        $display("[TB] run B: tw_ready pseudo-random");
        apply_stimulus(1, 1'b0, -1, 0);
        check_output("B_timeout",   int'(timed_out), 0);
        check_output("B_transfers", n_xfer, TOTAL);
        check_output("B_order",     order_err, 0);
        check_output("B_stall",     stall_err, 0);
        check_output("B_done",      n_done, 1);
        check_output("B_last_cnt",  n_last, 1);
        check_output("B_busy",      busy_err, 0);
        check_vector_table("B");

        $display("[TB] run C: start pulsed during stage 2");
        apply_stimulus(0, 1'b1, -1, 0);
        check_output("C_timeout",   int'(timed_out), 0);
        check_output("C_transfers", n_xfer, TOTAL);
        check_output("C_order",     order_err, 0);
        check_output("C_done",      n_done, 1);
        check_output("C_busy",      busy_err, 0);

        $display("[TB] run D: reset at stage 3 idx 7");
        apply_stimulus(0, 1'b0, 3, 7);
        check_output("D_reached",   int'(aborted), 1);
        check_output("D_transfers", n_xfer, 3 * PAIRS + 7);
        check_output("D_done",      n_done, 0);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("D_midreset");
        reset = 1'b0;
        spurious_done = 0;
        repeat (3) begin
            @(negedge clock);
            if (done || tw_bus.tw_valid) spurious_done++;
        end
        check_output("D_quiet_after", spurious_done, 0);

        $display("[TB] run E: restart after mid-sequence reset");
        apply_stimulus(0, 1'b0, -1, 0);
        check_output("E_timeout",   int'(timed_out), 0);
        check_output("E_latency",   latency, 3);
        check_output("E_transfers", n_xfer, TOTAL);
        check_output("E_order",     order_err, 0);
        check_output("E_done",      n_done, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
